// File: rtl/sp_mem_pkg.sv
// Shared types and constants for the SP memory responder.
// Holds the serving FSM state enum and the core address width.
package sp_mem_pkg;

    typedef enum logic {
        IDLE,
        SERVE
    } state_t;

    localparam int CORE_ADDR_W = 16;

endpackage

// File: rtl/sp_mem_ram.sv
// Single-port synchronous data RAM with registered read data.
// One access per cycle; a write cycle returns the old word on rdata.
module sp_mem_ram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    // Write port and registered read port share one address.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/sp_mem_responder.sv
// Serializes a batch of per-core requests onto one RAM port.
// Optional SPMEM_BROADCAST_EN: uniform-address read batches in one cycle.
module sp_mem_responder
    import sp_mem_pkg::*;
#(
    parameter int N_CORES = 4,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [N_CORES-1:0]            req_valid,
    input  logic [N_CORES-1:0]            req_we,
    input  logic [N_CORES*CORE_ADDR_W-1:0] req_addr,
    input  logic [N_CORES*DATA_W-1:0]     req_wdata,
    output logic [N_CORES-1:0]            rsp_valid,
    output logic [N_CORES*DATA_W-1:0]     rsp_data,
    output logic                          busy,
    output logic                          done,
    output logic                          overrun
);

    localparam int IDX_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;

    state_t state_q, state_d;

    logic [N_CORES-1:0]             pending_q, pending_d;
    logic [N_CORES-1:0]             we_q;
    logic [N_CORES-1:0][ADDR_W-1:0] addr_q;
    logic [N_CORES-1:0][DATA_W-1:0] wdata_q;
    logic [N_CORES-1:0][DATA_W-1:0] held_q;
    logic [N_CORES-1:0]             rsp_valid_q, rsp_valid_d;
    logic                           done_q, done_d;
    logic                           overrun_q;
    logic [IDX_W-1:0]               sel;
    logic                           bcast;
    logic                           ram_we;
    logic [ADDR_W-1:0]              ram_addr;
    logic [DATA_W-1:0]              ram_wdata;
    logic [DATA_W-1:0]              ram_rdata;
    logic                           addr_unused;

    // Address bits above ADDR_W wrap and are intentionally dropped.
    assign addr_unused = ^req_addr;

    // Lowest set bit of the pending mask picks the core served.
    always_comb begin
        sel = '0;
        for (int i = N_CORES - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                sel = IDX_W'(i);
            end
        end
    end

`ifdef SPMEM_BROADCAST_EN
    // All-read batch on one address can be answered in a single access.
    always_comb begin
        bcast = ((pending_q & we_q) == '0);
        for (int i = 0; i < N_CORES; i++) begin
            if (pending_q[i] && (addr_q[i] != addr_q[sel])) begin
                bcast = 1'b0;
            end
        end
    end
`else
    assign bcast = 1'b0;
`endif

    // Next-state, pending-mask update and RAM access selection.
    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        rsp_valid_d = '0;
        done_d      = 1'b0;
        ram_we      = 1'b0;
        ram_addr    = addr_q[sel];
        ram_wdata   = wdata_q[sel];
        unique case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    state_d   = SERVE;
                    pending_d = req_valid;
                end
            end
            SERVE: begin
                if (bcast) begin
                    rsp_valid_d = pending_q;
                    pending_d   = '0;
                end else begin
                    ram_we           = we_q[sel];
                    rsp_valid_d[sel] = ~we_q[sel];
                    pending_d[sel]   = 1'b0;
                end
                if (pending_d == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state, response strobes and per-core held read data.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            pending_q   <= '0;
            rsp_valid_q <= '0;
            done_q      <= 1'b0;
            overrun_q   <= 1'b0;
            held_q      <= '0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            rsp_valid_q <= rsp_valid_d;
            done_q      <= done_d;
            if ((state_q == SERVE) && (|req_valid)) begin
                overrun_q <= 1'b1;
            end
            for (int i = 0; i < N_CORES; i++) begin
                if (rsp_valid_q[i]) begin
                    held_q[i] <= ram_rdata;
                end
            end
        end
    end

    // Request payload is captured only when a batch is accepted.
    always_ff @(posedge clk) begin
        if ((state_q == IDLE) && (|req_valid)) begin
            we_q <= req_we;
            for (int i = 0; i < N_CORES; i++) begin
                addr_q[i]  <= req_addr[i*CORE_ADDR_W +: ADDR_W];
                wdata_q[i] <= req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Fresh RAM data in the response cycle, held copy otherwise.
    always_comb begin
        rsp_data = '0;
        for (int i = 0; i < N_CORES; i++) begin
            rsp_data[i*DATA_W +: DATA_W] =
                rsp_valid_q[i] ? ram_rdata : held_q[i];
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign busy      = (state_q == SERVE);
    assign done      = done_q;
    assign overrun   = overrun_q;

    sp_mem_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we & ~reset),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

endmodule
